// File: rtl/lab2_pkg.sv
// lab2_pkg: shared types and constants for the operand sequencer.
//   state_t  : sequencer FSM state encoding
//   ASCII    : command-framing characters and printable range bounds
//   is_print : true for bytes in the printable ASCII range
package lab2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_OP,
        GET_R2,
        GET_EQ,
        START,
        WAIT_RDY,
        SEND_RES,
        SEND_EOL
    } state_t;

    localparam logic [7:0] PLUS     = 8'h2B;
    localparam logic [7:0] MINUS    = 8'h2D;
    localparam logic [7:0] EQ       = 8'h3D;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] ESC      = 8'h1B;
    localparam logic [7:0] QMARK    = 8'h3F;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/lab2_timeout_ctr.sv
// lab2_timeout_ctr: up-counter that flags when the adder has been waited on
// for TIMEOUT_CYC cycles.
//   clk     : system clock
//   Gl_rst  : synchronous active-high reset
//   clr     : zero the count (held while not waiting)
//   en      : count this cycle
//   expired : count has reached TIMEOUT_CYC-1
module lab2_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic Gl_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    import lab2_pkg::*;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT_CYC - 1));

    // Saturate at the terminal value so the counter never wraps back to zero.
    always_ff @(posedge clk) begin
        if (Gl_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/lab2_operand_sequencer.sv
// lab2_operand_sequencer: parses "<r1><op><r2><term>" from a UART byte
// stream, launches the adder, and returns "<result>\r" to the transmitter.
//   clk, Gl_rst                 : clock, synchronous active-high reset
//   rx_data, rx_valid           : received byte and its one-cycle strobe
//   Gl_r1, Gl_r2, Gl_subtract   : operands and operation for the adder
//   Gl_adder_start              : one-cycle launch pulse
//   L2_adder_data, L2_adder_rdy : adder result and its one-cycle strobe
//   tx_data, tx_valid, tx_ready : valid/ready byte stream to the transmitter
//   seq_err                     : one-cycle pulse on parse error/timeout/overrun
//   seq_busy                    : high whenever not IDLE
//
// state    | meaning
// IDLE     | waiting for a printable first operand
// GET_OP   | waiting for '+' or '-'
// GET_R2   | waiting for a printable second operand
// GET_EQ   | waiting for '=' or CR
// START    | pulse Gl_adder_start
// WAIT_RDY | waiting for the adder, with timeout
// SEND_RES | offering the result byte
// SEND_EOL | offering the trailing CR
module lab2_operand_sequencer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       Gl_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] Gl_r1,
    output logic [7:0] Gl_r2,
    output logic       Gl_subtract,
    output logic       Gl_adder_start,
    input  logic [7:0] L2_adder_data,
    input  logic       L2_adder_rdy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       seq_err,
    output logic       seq_busy
);
    import lab2_pkg::*;

    state_t     state_q, state_d;
    logic [7:0] r1_q, r1_d;
    logic [7:0] r2_q, r2_d;
    logic       sub_q, sub_d;
    logic [7:0] result_q, result_d;
    logic       err_q, err_d;
    logic       expired;

    lab2_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .Gl_rst (Gl_rst),
        .clr    (state_q != WAIT_RDY),
        .en     (state_q == WAIT_RDY),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (Gl_rst) begin
            state_q  <= IDLE;
            r1_q     <= '0;
            r2_q     <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        sub_d    = sub_q;
        result_d = result_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && is_print(rx_data)) begin
                    r1_d    = rx_data;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (rx_valid) begin
                    if (rx_data == ESC) begin
                        state_d = IDLE;
                    end else if (rx_data == PLUS) begin
                        sub_d   = 1'b0;
                        state_d = GET_R2;
                    end else if (rx_data == MINUS) begin
                        sub_d   = 1'b1;
                        state_d = GET_R2;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            GET_R2: begin
                if (rx_valid) begin
                    if (rx_data == ESC) begin
                        state_d = IDLE;
                    end else if (is_print(rx_data)) begin
                        r2_d    = rx_data;
                        state_d = GET_EQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            GET_EQ: begin
                if (rx_valid) begin
                    if (rx_data == ESC) begin
                        state_d = IDLE;
                    end else if (rx_data == EQ || rx_data == CR) begin
                        state_d = START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            START: begin
                err_d   = rx_valid;
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                err_d = rx_valid;
                // A ready arriving on the terminal count still wins.
                if (L2_adder_rdy) begin
                    result_d = L2_adder_data;
                    state_d  = SEND_RES;
                end else if (expired) begin
                    result_d = QMARK;
                    err_d    = 1'b1;
                    state_d  = SEND_RES;
                end
            end
            SEND_RES: begin
                err_d = rx_valid;
                if (tx_ready) begin
                    state_d = SEND_EOL;
                end
            end
            SEND_EOL: begin
                err_d = rx_valid;
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Gl_r1          = r1_q;
    assign Gl_r2          = r2_q;
    assign Gl_subtract    = sub_q;
    assign Gl_adder_start = (state_q == START);
    assign tx_valid       = (state_q == SEND_RES) || (state_q == SEND_EOL);
    assign tx_data        = (state_q == SEND_RES) ? result_q :
                            (state_q == SEND_EOL) ? CR : 8'h00;
    assign seq_err        = err_q;
    assign seq_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lab2_operand_sequencer.sv
// Scoreboard bench for lab2_operand_sequencer: the driver pushes expected
// adder launches and transmitted bytes into queues, monitors pop and compare.
module tb_lab2_operand_sequencer;
    import lab2_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       Gl_rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] Gl_r1, Gl_r2;
    logic       Gl_subtract, Gl_adder_start;
    logic [7:0] L2_adder_data;
    logic       L2_adder_rdy;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       seq_err, seq_busy;

    always #5 clk = ~clk;

    lab2_operand_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .Gl_rst(Gl_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .Gl_r1(Gl_r1), .Gl_r2(Gl_r2), .Gl_subtract(Gl_subtract),
        .Gl_adder_start(Gl_adder_start), .L2_adder_data(L2_adder_data),
        .L2_adder_rdy(L2_adder_rdy), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .seq_err(seq_err), .seq_busy(seq_busy)
    );

    typedef struct {
        logic [7:0] r1;
        logic [7:0] r2;
        logic       sub;
        int         d;
        logic [7:0] data;
        bit         chk;
    } plan_t;

    plan_t       plan_q[$];
    logic [16:0] start_q[$];
    logic [7:0]  tx_q[$];

    int checks = 0;
    int failures = 0;
    int exp_err = 0;
    int err_seen = 0;
    bit adder_busy = 0;
    int ready_mode = 0;   // 0 random, 1 held low, 2 held high

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ---------------- monitors ----------------
    logic        hold_prev = 1'b0;
    logic        rst_prev = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  mon_e;
    logic [16:0] mon_s;

    always @(negedge clk) begin
        if (seq_err) err_seen++;
        if (Gl_adder_start) begin
            if (start_q.size() == 0) fail_now("start_unexpected");
            else begin
                mon_s = start_q.pop_front();
                check("start_operands", {Gl_r1, Gl_r2, Gl_subtract}, mon_s);
            end
        end
        if (hold_prev && !rst_prev) begin
            check("tx_hold_valid", tx_valid, 1'b1);
            check("tx_hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
            end else begin
                mon_e = tx_q.pop_front();
                check("tx_byte", tx_data, mon_e);
            end
        end
        hold_prev = tx_valid && !tx_ready;
        prev_data = tx_data;
        rst_prev  = Gl_rst;
    end

    // Adder model: answers each launch after the planned delay.
    plan_t rp;
    initial begin
        forever begin
            @(negedge clk);
            if (Gl_adder_start && plan_q.size() > 0) begin
                rp = plan_q.pop_front();
                adder_busy = 1;
                repeat (rp.d) @(posedge clk);
                #1;
                L2_adder_rdy  = 1'b1;
                L2_adder_data = rp.data;
                if (rp.chk && rp.d <= TO) begin
                    @(negedge clk);
                    check("ops_held", {Gl_r1, Gl_r2, Gl_subtract}, {rp.r1, rp.r2, rp.sub});
                end
                @(posedge clk);
                #1;
                L2_adder_rdy  = 1'b0;
                L2_adder_data = 8'($urandom);
                adder_busy = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = ($urandom % 4) != 0;
                1:       tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // ---------------- driver ----------------
    function automatic logic [7:0] rand_print();
        return 8'(32'h20 + $urandom_range(0, 94));
    endfunction

    function automatic logic [7:0] rand_nonprint();
        logic [7:0] v;
        do v = 8'($urandom); while ((v >= 8'h20 && v <= 8'h7E) || v == ESC);
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((seq_busy || adder_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now({name, "_idle"});
        repeat (2) @(negedge clk);
        check({name, "_err_count"}, err_seen, exp_err);
        check({name, "_tx_drained"}, tx_q.size(), 0);
        check({name, "_start_drained"}, start_q.size(), 0);
    endtask

    task automatic expect_cmd(input logic [7:0] r1, input logic [7:0] op, input logic [7:0] r2,
                              input int d, input logic [7:0] data, input bit with_tx);
        plan_t p;
        p.r1 = r1; p.r2 = r2; p.sub = (op == MINUS); p.d = d; p.data = data; p.chk = with_tx;
        plan_q.push_back(p);
        start_q.push_back({r1, r2, op == MINUS});
        if (with_tx) begin
            if (d <= TO) tx_q.push_back(data);
            else begin
                tx_q.push_back(QMARK);
                exp_err++;
            end
            tx_q.push_back(CR);
        end
    endtask

    task automatic run_good(input logic [7:0] r1, input logic [7:0] op, input logic [7:0] r2,
                            input logic [7:0] term, input int d, input logic [7:0] data);
        expect_cmd(r1, op, r2, d, data, 1'b1);
        send_byte(r1);
        check("busy_after_r1", seq_busy, 1'b1);
        send_byte(op);
        send_byte(r2);
        send_byte(term);
        wait_idle("good");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_r1"}, Gl_r1, 8'h00);
        check({tag, "_r2"}, Gl_r2, 8'h00);
        check({tag, "_sub"}, Gl_subtract, 1'b0);
        check({tag, "_start"}, Gl_adder_start, 1'b0);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_seq_err"}, seq_err, 1'b0);
        check({tag, "_busy"}, seq_busy, 1'b0);
    endtask

    logic [7:0] b1, bo, b2, bt;
    int         cat, n;

    initial begin
        Gl_rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        L2_adder_rdy = 1'b0;
        L2_adder_data = 8'h00;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        Gl_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Directed command set
        run_good("3", PLUS, "4", EQ, 3, 8'h37);
        run_good("9", MINUS, "2", CR, 5, 8'h37);
        send_byte("3");
        send_byte("*");
        exp_err++;
        wait_idle("bad_op");
        run_good("1", PLUS, "1", EQ, 2, 8'h32);
        run_good("5", PLUS, "5", EQ, 20, 8'h41);      // timeout, late rdy ignored
        run_good("6", MINUS, "1", EQ, TO, 8'h35);     // rdy on terminal count wins
        run_good("7", PLUS, "0", CR, TO + 1, 8'h37);  // one cycle too late
        send_byte("2");
        send_byte(PLUS);
        send_byte(ESC);
        wait_idle("esc_abort");

        // Result held under back-pressure, overrun during SEND_RES and SEND_EOL
        ready_mode = 1;
        expect_cmd("7", MINUS, "5", 3, 8'h5A, 1'b1);
        send_byte("7");
        send_byte(MINUS);
        send_byte("5");
        send_byte(EQ);
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_now("backpressure_tx_valid");
        send_byte("x");
        exp_err++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_valid", tx_valid, 1'b1);
        check("bp_data", tx_data, 8'h5A);
        ready_mode = 2;
        n = 0;
        while (!(tx_valid && tx_ready) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_now("backpressure_release");
        send_byte("A");
        exp_err++;
        ready_mode = 0;
        wait_idle("overrun");

        // Reset in WAIT_RDY
        expect_cmd("8", PLUS, "8", 10, 8'h70, 1'b0);
        send_byte("8");
        send_byte(PLUS);
        send_byte("8");
        send_byte(EQ);
        repeat (4) @(posedge clk);
        #1;
        Gl_rst = 1'b1;
        @(posedge clk);
        #1;
        Gl_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        wait_idle("after_reset");

        // Randomized commands
        for (int i = 0; i < 70; i++) begin
            cat = $urandom % 10;
            if ($urandom % 4 == 0) send_byte(rand_nonprint());
            b1 = rand_print();
            bo = ($urandom % 2) ? PLUS : MINUS;
            b2 = rand_print();
            bt = ($urandom % 2) ? EQ : CR;
            case (cat)
                0, 1, 2, 3, 4: run_good(b1, bo, b2, bt, $urandom_range(1, 12), 8'($urandom));
                9:             run_good(b1, bo, b2, bt, $urandom_range(TO - 1, TO + 2), 8'($urandom));
                5: begin
                    do bo = 8'($urandom); while (bo == PLUS || bo == MINUS || bo == ESC);
                    send_byte(b1); send_byte(bo);
                    exp_err++;
                    wait_idle("rand_bad_op");
                end
                6: begin
                    send_byte(b1); send_byte(bo); send_byte(rand_nonprint());
                    exp_err++;
                    wait_idle("rand_bad_r2");
                end
                7: begin
                    do bt = 8'($urandom); while (bt == EQ || bt == CR || bt == ESC);
                    send_byte(b1); send_byte(bo); send_byte(b2); send_byte(bt);
                    exp_err++;
                    wait_idle("rand_bad_eq");
                end
                default: begin
                    n = $urandom_range(0, 2);
                    send_byte(b1);
                    if (n > 0) send_byte(bo);
                    if (n > 1) send_byte(b2);
                    send_byte(ESC);
                    wait_idle("rand_esc");
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/lab2_operand_sequencer.md
LAB2_OPERAND_SEQUENCER -- requirements
Module: lab2_operand_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: cycles to wait for L2_adder_rdy after start before aborting.
REQ-002 SHALL have port clk, input, 1: the single global clock; all logic on posedge clk.
REQ-003 SHALL have port Gl_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port rx_data, input, 8: received ASCII byte.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle pulse; rx_data is valid in that cycle.
REQ-006 SHALL have port Gl_r1, output, 8: first operand (ASCII).
REQ-007 SHALL have port Gl_r2, output, 8: second operand (ASCII).
REQ-008 SHALL have port Gl_subtract, output, 1: 1 = subtract, 0 = add.
REQ-009 SHALL have port Gl_adder_start, output, 1: one-cycle pulse; operands ready.
REQ-010 SHALL have port L2_adder_data, input, 8: ASCII result from the adder.
REQ-011 SHALL have port L2_adder_rdy, input, 1: one-cycle pulse; L2_adder_data is valid.
REQ-012 SHALL have port tx_data, output, 8: byte to the transmitter.
REQ-013 SHALL have port tx_valid, output, 1: tx_data offered.
REQ-014 SHALL have port tx_ready, input, 1: transmitter accepts; a transfer occurs when tx_valid and tx_ready are both high.
REQ-015 SHALL have port seq_err, output, 1: one-cycle pulse on a parse error, timeout or overrun.
REQ-016 SHALL have port seq_busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, GET_OP, GET_R2, GET_EQ, START, WAIT_RDY, SEND_RES, SEND_EOL.
REQ-018 IDLE: on an rx byte in 0x20..0x7E, SHALL latch the byte into Gl_r1 and go to GET_OP; all other bytes are dropped silently.
REQ-019 GET_OP: on 0x2B ('+'), SHALL set Gl_subtract=0; on 0x2D ('-'), SHALL set Gl_subtract=1; either goes to GET_R2. Any other byte SHALL pulse seq_err and return to IDLE.
REQ-020 GET_R2: on a printable byte, SHALL latch it into Gl_r2 and go to GET_EQ; a non-printable byte SHALL pulse seq_err and return to IDLE.
REQ-021 GET_EQ: on 0x3D ('=') or 0x0D (CR), SHALL go to START; any other byte SHALL pulse seq_err and return to IDLE.
REQ-022 In GET_OP, GET_R2 and GET_EQ, byte 0x1B (ESC) SHALL return the FSM to IDLE with no seq_err.
REQ-023 START: SHALL assert Gl_adder_start for exactly one cycle, then go to WAIT_RDY.
REQ-024 SHALL hold Gl_r1, Gl_r2 and Gl_subtract stable from START until leaving WAIT_RDY.
REQ-025 WAIT_RDY: on L2_adder_rdy, SHALL capture L2_adder_data into the result register and go to SEND_RES.
REQ-026 WAIT_RDY: the timeout counter SHALL clear on entry and increment each cycle.
REQ-027 When the timeout counter reaches TIMEOUT_CYC-1 with no rdy, SHALL load result=0x3F ('?'), pulse seq_err and go to SEND_RES.
REQ-028 If rdy and timeout coincide in the same cycle, rdy SHALL win and no seq_err is raised.
REQ-029 L2_adder_rdy outside WAIT_RDY SHALL be ignored.
REQ-030 SEND_RES: SHALL drive tx_valid=1 with tx_data=result, held stable until tx_ready; on transfer go to SEND_EOL.
REQ-031 SEND_EOL: SHALL offer 0x0D with the same handshake rule, then go to IDLE.
REQ-032 rx_valid in START, WAIT_RDY, SEND_RES or SEND_EOL SHALL drop the byte and pulse seq_err (overrun).
REQ-033 If a transfer completes and an overrun occurs in the same cycle, both effects SHALL occur.
REQ-034 tx_valid SHALL be 0 in all states other than SEND_RES and SEND_EOL.
REQ-035 Latency SHALL be: START exactly one cycle after the terminator byte; tx_valid exactly one cycle after rdy or timeout.

Reset
REQ-036 Gl_rst SHALL force state=IDLE, Gl_r1=0, Gl_r2=0, Gl_subtract=0, Gl_adder_start=0, tx_valid=0, tx_data=0, seq_err=0, seq_busy=0, result=0, timeout counter=0.
REQ-037 Reset asserted in any state, including mid-handshake, SHALL take effect on the next edge and have priority over all other inputs.

Structure
REQ-038 Package lab2_pkg SHALL hold the state typedef and the ASCII constants (PLUS, MINUS, EQ, CR, ESC, QMARK, PRINT_LO=0x20, PRINT_HI=0x7E).
REQ-039 The timeout counter SHALL be sub-module lab2_timeout_ctr (inputs clk, Gl_rst, clr, en; parameter TIMEOUT_CYC; output expired).

Verification
REQ-040 Bytes '3','+','4','=', model rdy 3 cycles after start with 0x37 -> one start pulse with r1=0x33, r2=0x34, sub=0; tx sends 0x37 then 0x0D; seq_err never asserted.
REQ-041 Bytes '9','-','2',CR, rdy returning 0x37 -> sub=1 held through WAIT_RDY; tx sends 0x37, 0x0D.
REQ-042 Bytes '3','*' -> seq_err pulse, FSM back in IDLE, no start; then '1','+','1','=' completes normally.
REQ-043 Valid command with no rdy -> after 16 cycles seq_err pulse; tx sends 0x3F, 0x0D; a late rdy is ignored.
REQ-044 tx_ready held low 5 cycles in SEND_RES -> tx_data=result stable and tx_valid high throughout; an rx byte arriving meanwhile -> seq_err pulse.
REQ-045 Gl_rst pulsed in WAIT_RDY -> all outputs at reset values the next cycle; a subsequent rdy produces no tx.
